// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver for the 16-bit link: hunts for the sync word to
// find word alignment, then delivers MSB-first words through a one-entry holding register.
module deserializer_rx #(
   parameter int                 WIDTH     = 16,
   parameter logic [WIDTH-1:0]   SYNC_WORD = 16'hBC5A,
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sdata,
   input  logic              bit_en,
   input  logic              rx_resync,
   input  logic              pready,
   input  logic              ovf_clr,
   output logic [WIDTH-1:0]  pdata,
   output logic              pvalid,
   output logic              locked,
   output logic              overflow,
   output logic [CNT_W-1:0]  word_count
);

   localparam int BW = $clog2(WIDTH);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t            state;
   logic [WIDTH-1:0]  sr;
   logic [BW-1:0]     bit_cnt;
   logic [WIDTH-1:0]  win;
   logic              word_done;
   logic              is_sync;
   logic              can_load;

   // Window includes the bit arriving this cycle so matches and words land on the sampling edge.
   assign win       = {sr[WIDTH-2:0], sdata};
   assign is_sync   = (win == SYNC_WORD);
   assign word_done = bit_en && (state == LOCKED) && (bit_cnt == BW'(WIDTH-1));
   assign can_load  = !pvalid || pready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= HUNT;
         sr         <= '0;
         bit_cnt    <= '0;
         pdata      <= '0;
         pvalid     <= 1'b0;
         locked     <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         if (bit_en)
            sr <= win;

         // Defaults: a completed handshake empties the holder, ovf_clr clears;
         // a new word or a drop below overrides these.
         if (pvalid && pready)
            pvalid <= 1'b0;
         if (ovf_clr)
            overflow <= 1'b0;

         if (rx_resync) begin
            state   <= HUNT;
            bit_cnt <= '0;
            locked  <= 1'b0;
         end else if (bit_en) begin
            case (state)
               HUNT: begin
                  if (is_sync) begin
                     state   <= LOCKED;
                     bit_cnt <= '0;
                     locked  <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (word_done) begin
                     bit_cnt <= '0;
                     if (!is_sync) begin
                        if (can_load) begin
                           pdata      <= win;
                           pvalid     <= 1'b1;
                           word_count <= word_count + 1'b1;
                        end else begin
                           overflow <= 1'b1;
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= HUNT;
                  bit_cnt <= '0;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_deserializer_rx.sv
// Scoreboard bench for deserializer_rx: expected words are queued as they are
// serialised and checked when the DUT hands them over on pvalid&&pready.
module tb_deserializer_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sdata;
   logic        bit_en;
   logic        rx_resync;
   logic        pready;
   logic        ovf_clr;
   logic [15:0] pdata;
   logic        pvalid;
   logic        locked;
   logic        overflow;
   logic [15:0] word_count;

   int vectors = 0;
   int errors  = 0;
   logic [15:0] sb[$];

   deserializer_rx dut (
      .clk(clk), .reset_n(reset_n), .sdata(sdata), .bit_en(bit_en),
      .rx_resync(rx_resync), .pready(pready), .ovf_clr(ovf_clr),
      .pdata(pdata), .pvalid(pvalid), .locked(locked),
      .overflow(overflow), .word_count(word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake completes on the next rising edge; compare against the oldest expected word.
   always @(negedge clk) begin
      if (reset_n && pvalid && pready) begin
         chk("sb_nonempty", (sb.size() != 0), 1);
         if (sb.size() != 0)
            chk("sb_word", pdata, sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sdata  = b;
      bit_en = 1'b1;
      tick();
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--)
         send_bit(w[i]);
   endtask

   task automatic idle(input int n);
      bit_en = 1'b0;
      sdata  = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
         tick();
   endtask

   initial begin
      logic [4:0]  junk;
      logic [15:0] w;
      reset_n = 1'b0; sdata = 1'b0; bit_en = 1'b0; rx_resync = 1'b0;
      pready = 1'b1; ovf_clr = 1'b0;
      #12;
      chk("rst_pdata", pdata, 0);
      chk("rst_pvalid", pvalid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", word_count, 0);
      reset_n = 1'b1;
      tick();

      // 1: junk, sync, first word; pvalid is a one-cycle pulse with pready high
      junk = 5'b01100;
      for (int i = 4; i >= 0; i--)
         send_bit(junk[i]);
      send_word(16'hBC5A);
      chk("t1_locked", locked, 1);
      sb.push_back(16'h1234);
      send_word(16'h1234);
      chk("t1_pvalid", pvalid, 1);
      chk("t1_pdata", pdata, 16'h1234);
      chk("t1_count", word_count, 1);
      idle(1);
      chk("t1_pulse", pvalid, 0);

      // 2: consumer stalls, second word is dropped
      pready = 1'b0;
      sb.push_back(16'hA5A5);
      send_word(16'hA5A5);
      chk("t2_ovf0", overflow, 0);
      send_word(16'h0F0F);
      chk("t2_pdata", pdata, 16'hA5A5);
      chk("t2_pvalid", pvalid, 1);
      chk("t2_ovf", overflow, 1);
      chk("t2_count", word_count, 2);
      bit_en = 1'b0;
      pready = 1'b1;
      tick();
      chk("t2_drain", pvalid, 0);
      chk("t2_hold", pdata, 16'hA5A5);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t2_ovfclr", overflow, 0);

      // 3: in-stream sync word is filler, never delivered
      send_word(16'hBC5A);
      chk("t3_nosync", pvalid, 0);
      chk("t3_count0", word_count, 2);
      sb.push_back(16'hC3C3);
      send_word(16'hC3C3);
      chk("t3_pdata", pdata, 16'hC3C3);
      chk("t3_count", word_count, 3);
      idle(1);

      // 4: gaps between every bit
      w = 16'h8001;
      sb.push_back(w);
      for (int i = 15; i >= 0; i--) begin
         send_bit(w[i]);
         if (i != 0) idle(1 + (i % 3));
      end
      chk("t4_pdata", pdata, 16'h8001);
      chk("t4_count", word_count, 4);
      idle(1);

      // 5: resync mid-word leaves the holder alone
      pready = 1'b0;
      sb.push_back(16'h4444);
      send_word(16'h4444);
      for (int i = 0; i < 8; i++)
         send_bit(1'b0);
      bit_en = 1'b0;
      rx_resync = 1'b1;
      tick();
      rx_resync = 1'b0;
      chk("t5_unlock", locked, 0);
      chk("t5_pvalid", pvalid, 1);
      chk("t5_pdata", pdata, 16'h4444);
      pready = 1'b1;
      tick();
      for (int i = 0; i < 8; i++)
         send_bit(1'b0);
      chk("t5_hunt", locked, 0);
      send_word(16'hBC5A);
      chk("t5_relock", locked, 1);
      sb.push_back(16'h7777);
      send_word(16'h7777);
      chk("t5_pdata2", pdata, 16'h7777);
      chk("t5_count", word_count, 6);
      idle(1);

      // 6: async reset 9 bits into a word
      w = 16'h5555;
      for (int i = 15; i >= 7; i--)
         send_bit(w[i]);
      bit_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("t6_pdata", pdata, 0);
      chk("t6_locked", locked, 0);
      chk("t6_count", word_count, 0);
      chk("t6_pvalid", pvalid, 0);
      tick();
      reset_n = 1'b1;
      tick();
      send_word(16'h0000);
      chk("t6_nolock", locked, 0);
      send_word(16'hBC5A);
      chk("t6_relock", locked, 1);
      sb.push_back(16'h1111);
      send_word(16'h1111);
      chk("t6_pdata2", pdata, 16'h1111);
      chk("t6_count2", word_count, 1);
      idle(2);

      chk("sb_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
